pc_fetch_queue: RTL and testbench

PC_FETCH_QUEUE -- requirements
Module: pc_fetch_queue

---
 rtl/pc_fetch_queue_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 116 +++++++++++
 rtl/pc_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_queue.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// pc_fetch_queue_pkg
// Shared constants and types for the instruction fetch front end:
//   ADDR_W / DATA_W    - bus address and data widths
//   RESET_PC_DEFAULT   - boot vector fetched first after reset
//   INST_BYTES         - fetch PC increment per instruction
//   redir_src_e        - which redirect source (if any) owns the cycle
//   cnt_width()        - width of the in-flight counters for a queue depth
// ----------------------------------------------------------------------------
package pc_fetch_queue_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [ADDR_W-1:0] INST_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_FLUSH  = 2'd1,
        REDIR_BRANCH = 2'd2
    } redir_src_e;

    // Counters must hold the value DEPTH itself, hence one bit beyond log2.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Instruction queue with out-of-band fill. An entry is allocated (pc known,
// instruction pending) when the request is accepted, filled later when the
// bus returns data in order, and popped from the head once filled.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clear        - synchronous empty (redirect); drops every entry
//   alloc        - append entry at tail with pc = alloc_pc, unfilled
//   fill         - write fill_inst into the oldest unfilled entry
//   pop          - remove head entry
//   count        - allocated entries (filled or not)
//   head_filled  - queue non-empty and head entry holds its instruction
//   head_pc      - head entry pc
//   head_inst    - head entry instruction
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_fifo
    import pc_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      alloc,
    input  logic [ADDR_W-1:0]         alloc_pc,
    input  logic                      fill,
    input  logic [DATA_W-1:0]         fill_inst,
    input  logic                      pop,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      head_filled,
    output logic [ADDR_W-1:0]         head_pc,
    output logic [DATA_W-1:0]         head_inst
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PW:0]       alloc_ptr_reg;
    logic [PW:0]       fill_ptr_reg;
    logic [PW:0]       pop_ptr_reg;

    logic [PW-1:0]     alloc_idx;
    logic [PW-1:0]     fill_idx;
    logic [PW-1:0]     pop_idx;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [DEPTH-1:0]  filled_vec;

    assign alloc_idx = alloc_ptr_reg[PW-1:0];
    assign fill_idx  = fill_ptr_reg[PW-1:0];
    assign pop_idx   = pop_ptr_reg[PW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            pop_ptr_reg   <= '0;
        end else if (clear) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            pop_ptr_reg   <= '0;
        end else begin
            alloc_ptr_reg <= alloc_ptr_reg + (PW+1)'(alloc);
            fill_ptr_reg  <= fill_ptr_reg  + (PW+1)'(fill);
            pop_ptr_reg   <= pop_ptr_reg   + (PW+1)'(pop);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ADDR_W-1:0] pc_reg;
            logic [DATA_W-1:0] inst_reg;
            logic              filled_reg;
            logic              alloc_hit;
            logic              fill_hit;

            assign alloc_hit = alloc && (alloc_idx == PW'(gi));
            assign fill_hit  = fill  && (fill_idx  == PW'(gi));

            // Allocation clears the filled bit, so a popped slot never needs
            // explicit invalidation; the fill pointer always trails alloc, so
            // both hits on one slot in the same cycle cannot happen.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pc_reg     <= '0;
                    inst_reg   <= '0;
                    filled_reg <= 1'b0;
                end else if (clear) begin
                    filled_reg <= 1'b0;
                end else begin
                    if (alloc_hit) begin
                        pc_reg     <= alloc_pc;
                        filled_reg <= 1'b0;
                    end
                    if (fill_hit) begin
                        inst_reg   <= fill_inst;
                        filled_reg <= 1'b1;
                    end
                end
            end

            assign pc_mem[gi]     = pc_reg;
            assign inst_mem[gi]   = inst_reg;
            assign filled_vec[gi] = filled_reg;
        end
    endgenerate

    assign count       = alloc_ptr_reg - pop_ptr_reg;
    assign head_filled = (count != '0) && filled_vec[pop_idx];
    assign head_pc     = pc_mem[pop_idx];
    assign head_inst   = inst_mem[pop_idx];

endmodule

// File: rtl/pc_fetch_queue.sv
// ----------------------------------------------------------------------------
// pc_fetch_queue
// Fetch PC generator plus instruction queue in front of an SRAM-like
// instruction bus (separate addr_ok / data_ok handshakes, in-order data).
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   flush_i, flush_pc_i      - exception/eret redirect (highest priority)
//   branch_en_i, branch_pc_i - branch redirect from decode
//   inst_req, inst_addr      - request valid and address (= fetch PC)
//   inst_addr_ok             - request accepted this cycle
//   inst_data_ok, inst_rdata - returned instruction, in request order
//   out_valid, out_ready     - head handshake towards decode
//   out_pc, out_inst         - head entry
// Responses to requests issued before a redirect are counted in cancel_reg
// and silently dropped when they come back.
// ----------------------------------------------------------------------------
module pc_fetch_queue
    import pc_fetch_queue_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst
);

    localparam int CW = cnt_width(DEPTH);

    logic [ADDR_W-1:0] fpc_reg, fpc_next;
    logic [CW-1:0]     outstanding_reg, outstanding_next;
    logic [CW-1:0]     cancel_reg, cancel_next;
    logic [CW-1:0]     in_flight;

    redir_src_e        redir_src;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    logic [CW-1:0]     fifo_count;
    logic [CW:0]       slots_used;
    logic              head_filled;
    logic              accepted;
    logic              fill;
    logic              drop;
    logic              pop;

    // Flush outranks branch.
    always_comb begin
        redir_src   = REDIR_NONE;
        redirect_pc = flush_pc_i;
        if (flush_i) begin
            redir_src   = REDIR_FLUSH;
            redirect_pc = flush_pc_i;
        end else if (branch_en_i) begin
            redir_src   = REDIR_BRANCH;
            redirect_pc = branch_pc_i;
        end
    end

    assign redirect = (redir_src != REDIR_NONE);

    // Every allocated entry (filled or awaiting data) plus every response
    // that will be thrown away occupies a slot of the budget. Keeping the
    // sum below DEPTH bounds outstanding + cancel by DEPTH, so neither
    // counter can overflow even across back-to-back redirects.
    assign slots_used = {1'b0, fifo_count} + {1'b0, cancel_reg};
    assign inst_req   = ~rst & ~redirect & (slots_used < (CW+1)'(DEPTH));
    assign inst_addr  = fpc_reg;
    assign accepted   = inst_req & inst_addr_ok;

    // Data during a redirect belongs to the old stream and is never stored.
    assign fill = inst_data_ok & ~redirect & (cancel_reg == '0) & (outstanding_reg != '0);
    assign drop = inst_data_ok & ~redirect & (cancel_reg != '0);

    assign out_valid = head_filled & ~redirect;
    assign pop       = out_valid & out_ready;

    always_comb begin
        fpc_next         = fpc_reg;
        outstanding_next = outstanding_reg;
        cancel_next      = cancel_reg;
        in_flight        = outstanding_reg + cancel_reg + CW'(accepted);
        if (redirect) begin
            fpc_next         = redirect_pc;
            outstanding_next = '0;
            // The response arriving now (if any) retires one in-flight slot.
            if (inst_data_ok && (in_flight != '0)) begin
                cancel_next = in_flight - CW'(1);
            end else begin
                cancel_next = in_flight;
            end
        end else begin
            if (accepted) begin
                fpc_next = fpc_reg + INST_BYTES;
            end
            outstanding_next = outstanding_reg + CW'(accepted) - CW'(fill);
            if (drop) begin
                cancel_next = cancel_reg - CW'(1);
            end
        end
    end

    // Reset also forgets any bus response in flight: the bus restarts too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_reg         <= RESET_PC;
            outstanding_reg <= '0;
            cancel_reg      <= '0;
        end else begin
            fpc_reg         <= fpc_next;
            outstanding_reg <= outstanding_next;
            cancel_reg      <= cancel_next;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear       (redirect),
        .alloc       (accepted),
        .alloc_pc    (fpc_reg),
        .fill        (fill),
        .fill_inst   (inst_rdata),
        .pop         (pop),
        .count       (fifo_count),
        .head_filled (head_filled),
        .head_pc     (out_pc),
        .head_inst   (out_inst)
    );

endmodule

// File: tb/tb_pc_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_queue
// Randomised and directed stimulus against a queue-based reference model:
// the model keeps the list of queued fetches and the list of bus requests
// still in flight (each marked live or stale), and predicts the outputs.
// ----------------------------------------------------------------------------
module tb_pc_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_en_i;
    logic [31:0] branch_pc_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    pc_fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .branch_en_i  (branch_en_i),
        .branch_pc_i  (branch_pc_i),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
    } ent_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        live;
    } flight_t;

    ent_t        entries[$];
    flight_t     inflight[$];
    logic [31:0] pops[$];
    logic [31:0] fpc_m;
    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    int          n_discard = 0;
    bit          seen_bad = 1'b0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Predict this cycle's outputs, compare, then advance the model to the
    // state after the coming rising edge.
    task automatic model_step();
        logic        redir;
        logic [31:0] rpc;
        int          dead;
        logic        ereq;
        logic        evalid;
        logic        acc;
        logic        done;
        flight_t     r;
        flight_t     f;
        ent_t        e;

        redir = flush_i | branch_en_i;
        rpc   = flush_i ? flush_pc_i : branch_pc_i;
        dead  = 0;
        foreach (inflight[i]) if (!inflight[i].live) dead++;
        ereq   = !redir && ((entries.size() + dead) < DEPTH);
        evalid = !redir && (entries.size() > 0) && entries[0].filled;

        check("inst_req", {31'd0, inst_req}, {31'd0, ereq});
        check("inst_addr", inst_addr, fpc_m);
        check("out_valid", {31'd0, out_valid}, {31'd0, evalid});
        if (evalid) begin
            check("out_pc", out_pc, entries[0].pc);
            check("out_inst", out_inst, entries[0].inst);
        end

        acc = ereq && inst_addr_ok;

        if (inst_data_ok) begin
            r = inflight.pop_front();
            if (redir || !r.live) begin
                n_discard++;
            end else begin
                done = 1'b0;
                for (int i = 0; i < entries.size(); i++) begin
                    if (!done && !entries[i].filled) begin
                        e        = entries[i];
                        e.inst   = data_of(r.addr);
                        e.filled = 1'b1;
                        entries[i] = e;
                        done     = 1'b1;
                    end
                end
            end
        end

        if (evalid && out_ready) begin
            $display("pop pc=%08h inst=%08h", entries[0].pc, entries[0].inst);
            pops.push_back(entries[0].pc);
            void'(entries.pop_front());
        end

        if (acc) begin
            n_acc++;
            if (fpc_m == 32'h8000_1000) seen_bad = 1'b1;
            e.pc = fpc_m; e.inst = '0; e.filled = 1'b0;
            entries.push_back(e);
            f.addr = fpc_m; f.live = 1'b1;
            inflight.push_back(f);
            fpc_m = fpc_m + 32'd4;
        end

        if (redir) begin
            entries.delete();
            for (int i = 0; i < inflight.size(); i++) begin
                f = inflight[i];
                f.live = 1'b0;
                inflight[i] = f;
            end
            fpc_m = rpc;
        end
    endtask

    task automatic cycle(input logic fl, input logic [31:0] fpv, input logic br,
                         input logic [31:0] bpv, input logic aok, input logic dok,
                         input logic rdy);
        @(negedge clk);
        flush_i      = fl;
        flush_pc_i   = fpv;
        branch_en_i  = br;
        branch_pc_i  = bpv;
        inst_addr_ok = aok;
        out_ready    = rdy;
        inst_data_ok = dok && (inflight.size() > 0);
        inst_rdata   = inst_data_ok ? data_of(inflight[0].addr) : $urandom;
        #1;
        model_step();
    endtask

    task automatic apply_reset();
        logic pre_valid;
        @(negedge clk);
        flush_i      = 1'b0;
        branch_en_i  = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        out_ready    = 1'b0;
        #1;
        pre_valid = rst ? 1'b0 : ((entries.size() > 0) && entries[0].filled);
        check("pre_rst_valid", {31'd0, out_valid}, {31'd0, pre_valid});
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inst_req", {31'd0, inst_req}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_inst_addr", inst_addr, RESET_PC);
        entries.delete();
        inflight.delete();
        fpc_m = RESET_PC;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("req_after_rst", {31'd0, inst_req}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          acc0;
        int          disc0;
        logic        fl, br, aok, dok, rdy;
        logic [31:0] fp, bp;

        rst          = 1'b1;
        flush_i      = 1'b0;
        flush_pc_i   = '0;
        branch_en_i  = 1'b0;
        branch_pc_i  = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        out_ready    = 1'b0;
        fpc_m        = RESET_PC;

        // Sequential fetch with an always-ready bus and consumer.
        apply_reset();
        base = pops.size();
        repeat (5) cycle(0, 0, 0, 0, 1, 1, 1);
        acc0 = pops.size();
        repeat (5) cycle(0, 0, 0, 0, 1, 1, 1);
        check("seq0", pops.size() > base + 0 ? pops[base + 0] : 32'hX, 32'hBFC0_0000);
        check("seq1", pops.size() > base + 1 ? pops[base + 1] : 32'hX, 32'hBFC0_0004);
        check("seq2", pops.size() > base + 2 ? pops[base + 2] : 32'hX, 32'hBFC0_0008);
        check("steady_pops", pops.size() - acc0, 5);

        // Back-pressure: queue fills to DEPTH, then one pop frees one slot.
        apply_reset();
        acc0 = n_acc;
        repeat (12) cycle(0, 0, 0, 0, 1, 1, 0);
        check("full_accepts", n_acc - acc0, DEPTH);
        check("full_req_low", {31'd0, inst_req}, 32'd0);
        acc0 = n_acc;
        cycle(0, 0, 0, 0, 1, 1, 1);
        repeat (6) cycle(0, 0, 0, 0, 1, 1, 0);
        check("one_pop_one_req", n_acc - acc0, 1);

        // Flush with two requests outstanding.
        apply_reset();
        repeat (2) cycle(0, 0, 0, 0, 1, 0, 0);
        disc0 = n_discard;
        base  = pops.size();
        cycle(1, 32'hBFC0_0380, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 1, 1);
        check("flush_addr", inst_addr, 32'hBFC0_0380);
        repeat (8) cycle(0, 0, 0, 0, 1, 1, 1);
        check("flush_discards", n_discard - disc0, 2);
        check("flush_first_pc", pops.size() > base ? pops[base] : 32'hX, 32'hBFC0_0380);

        // Flush and branch together: flush wins, branch target never fetched.
        apply_reset();
        repeat (2) cycle(0, 0, 0, 0, 1, 1, 1);
        seen_bad = 1'b0;
        cycle(1, 32'hBFC0_0380, 1, 32'h8000_1000, 1, 1, 1);
        cycle(0, 0, 0, 0, 1, 1, 1);
        check("prio_addr", inst_addr, 32'hBFC0_0380);
        repeat (8) cycle(0, 0, 0, 0, 1, 1, 1);
        check("prio_no_branch", {31'd0, seen_bad}, 32'd0);

        // Redirect coinciding with addr_ok and data_ok.
        apply_reset();
        repeat (2) cycle(0, 0, 0, 0, 1, 0, 0);
        disc0 = n_discard;
        base  = pops.size();
        cycle(0, 0, 1, 32'h0040_0000, 1, 1, 1);
        check("same_cycle_drop", n_discard - disc0, 1);
        repeat (8) cycle(0, 0, 0, 0, 1, 1, 1);
        check("same_cycle_discards", n_discard - disc0, 2);
        check("same_cycle_first_pc", pops.size() > base ? pops[base] : 32'hX, 32'h0040_0000);

        // Reset with a full queue: outputs drop at once, restart at RESET_PC.
        repeat (10) cycle(0, 0, 0, 0, 1, 1, 0);
        apply_reset();
        cycle(0, 0, 0, 0, 1, 1, 1);

        // Random traffic, including unaligned redirect targets.
        for (int c = 0; c < 800; c++) begin
            if (c == 400) apply_reset();
            fl  = ($urandom_range(0, 99) < 3);
            br  = ($urandom_range(0, 99) < 6);
            fp  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            bp  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            aok = ($urandom_range(0, 99) < 70);
            dok = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 70);
            cycle(fl, fp, br, bp, aok, dok, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
